// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-port ALU arbiter.
// The optional repeat-pass feature is enabled by defining ALU_ARB_REPEAT_EN.
package alu_arb_pkg;

  localparam int DW   = 8;
  localparam int OPW  = 4;
  localparam int RPTW = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // Opcodes understood by the external ALU; the arbiter itself never decodes them.
  localparam logic [OPW-1:0] OP_ADD = 4'b0000;
  localparam logic [OPW-1:0] OP_SUB = 4'b0001;
  localparam logic [OPW-1:0] OP_ROL = 4'b1000;
  localparam logic [OPW-1:0] OP_ROR = 4'b1001;
  localparam logic [OPW-1:0] OP_DEC = 4'b1010;
  localparam logic [OPW-1:0] OP_INV = 4'b1011;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant: on a tie the port not granted last time wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between the CPU (port 0) and scan engine (port 1).
// Define ALU_ARB_REPEAT_EN to let a request re-apply its opcode to its own result.
module alu_arbiter #(
  parameter int DW   = 8,
  parameter int OPW  = 4,
  parameter int RPTW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [2*OPW-1:0]  req_op,
  input  logic [2*DW-1:0]   req_a,
  input  logic [2*DW-1:0]   req_b,
  input  logic [2*RPTW-1:0] req_rpt,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [DW-1:0]     rsp_data,
  output logic [DW-1:0]     alu_a,
  output logic [DW-1:0]     alu_b,
  output logic [OPW-1:0]    alu_opcode,
  input  logic [DW-1:0]     alu_y,
  output logic              busy
);

  import alu_arb_pkg::*;

  state_e          state_q;
  logic            own_q;
  logic            last_q;
  logic [OPW-1:0]  op_q;
  logic [DW-1:0]   a_q;
  logic [DW-1:0]   b_q;
  logic [DW-1:0]   res_q;
  logic [1:0]      gnt;
  logic [OPW-1:0]  selOp;
  logic [DW-1:0]   selA;
  logic [DW-1:0]   selB;

  rr_arb2 u_rr_arb2 (
    .req  (req_valid),
    .last (last_q),
    .gnt  (gnt)
  );

  assign selOp = gnt[1] ? req_op[2*OPW-1:OPW] : req_op[OPW-1:0];
  assign selA  = gnt[1] ? req_a[2*DW-1:DW]    : req_a[DW-1:0];
  assign selB  = gnt[1] ? req_b[2*DW-1:DW]    : req_b[DW-1:0];

`ifdef ALU_ARB_REPEAT_EN
  logic [RPTW-1:0] cnt_q;
  logic [RPTW-1:0] selRpt;
  assign selRpt = gnt[1] ? req_rpt[2*RPTW-1:RPTW] : req_rpt[RPTW-1:0];
`else
  logic unused_rpt;
  assign unused_rpt = ^req_rpt;
`endif

  assign req_ready  = (state_q == IDLE) ? gnt : 2'b00;
  assign rsp_valid  = (state_q == RESP) ? (own_q ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_data   = res_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_opcode = op_q;
  assign busy       = (state_q != IDLE);

  // In EXEC the ALU output feeds back into operand A until the pass count runs out.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      own_q   <= 1'b0;
      last_q  <= 1'b1;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
`ifdef ALU_ARB_REPEAT_EN
      cnt_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (|gnt) begin
            own_q   <= gnt[1];
            op_q    <= selOp;
            a_q     <= selA;
            b_q     <= selB;
`ifdef ALU_ARB_REPEAT_EN
            cnt_q   <= selRpt;
`endif
            state_q <= EXEC;
          end
        end
        EXEC: begin
          res_q <= alu_y;
`ifdef ALU_ARB_REPEAT_EN
          if (cnt_q != '0) begin
            a_q   <= alu_y;
            cnt_q <= cnt_q - RPTW'(1);
          end else begin
            state_q <= RESP;
          end
`else
          state_q <= RESP;
`endif
        end
        RESP: begin
          if (rsp_ready[own_q]) begin
            last_q  <= own_q;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU; expectations follow ALU_ARB_REPEAT_EN.
module tb_alu_arbiter;

  import alu_arb_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [7:0]   req_op;
  logic [15:0]  req_a;
  logic [15:0]  req_b;
  logic [5:0]   req_rpt;
  logic [1:0]   rsp_valid;
  logic [1:0]   rsp_ready;
  logic [7:0]   rsp_data;
  logic [7:0]   alu_a;
  logic [7:0]   alu_b;
  logic [3:0]   alu_opcode;
  logic [7:0]   alu_y;
  logic         busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       port;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] rpt;
    logic [7:0] expData;
  } vec_t;

  vec_t vecs [8];

  always #5 clk = ~clk;

  alu_arbiter #(.DW(8), .OPW(4), .RPTW(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_rpt    (req_rpt),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_y      (alu_y),
    .busy       (busy)
  );

  // Behavioural stand-in for the shared ALU
  always_comb begin
    alu_y = 8'h00;
    case (alu_opcode)
      OP_ADD:  alu_y = alu_a + alu_b;
      OP_SUB:  alu_y = alu_a - alu_b;
      OP_ROL:  alu_y = {alu_a[6:0], alu_a[7]};
      OP_ROR:  alu_y = {alu_a[0], alu_a[7:1]};
      OP_DEC:  alu_y = alu_a - 8'd1;
      OP_INV:  alu_y = ~alu_a;
      default: alu_y = 8'h00;
    endcase
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic setPort(input logic port, input logic [3:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [2:0] rpt);
    if (port) begin
      req_op[7:4] = op; req_a[15:8] = a; req_b[15:8] = b; req_rpt[5:3] = rpt;
    end else begin
      req_op[3:0] = op; req_a[7:0] = a;  req_b[7:0] = b;  req_rpt[2:0] = rpt;
    end
  endtask

  // Called just after the accepting edge; returns cycles from accept to rsp_valid
  task automatic waitRsp(output int lat);
    @(negedge clk);
    lat = 1;
    while (rsp_valid == 2'b00 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  function automatic int expLatency(input logic [2:0] rpt);
`ifdef ALU_ARB_REPEAT_EN
    return 2 + int'(rpt);
`else
    return 2 + 0 * int'(rpt);
`endif
  endfunction

  task automatic applyStimulus(input vec_t v, input int idx);
    int lat;
    logic [1:0] oneHot;
    oneHot = v.port ? 2'b10 : 2'b01;
    @(negedge clk);
    setPort(v.port, v.op, v.a, v.b, v.rpt);
    req_valid = oneHot;
    #1 checkOutput($sformatf("vec%0d req_ready", idx), 32'(req_ready), 32'(oneHot));
    @(posedge clk);
    #1 req_valid = 2'b00;
    waitRsp(lat);
    checkOutput($sformatf("vec%0d latency", idx), lat, expLatency(v.rpt));
    checkOutput($sformatf("vec%0d rsp_valid", idx), 32'(rsp_valid), 32'(oneHot));
    checkOutput($sformatf("vec%0d rsp_data", idx), 32'(rsp_data), 32'(v.expData));
    rsp_ready = oneHot;
    @(posedge clk);
    #1 rsp_ready = 2'b00;
    checkOutput($sformatf("vec%0d busy after", idx), 32'(busy), 32'd0);
    checkOutput($sformatf("vec%0d rsp_valid after", idx), 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;

`ifdef ALU_ARB_REPEAT_EN
    vecs[0] = '{1'b0, OP_ADD, 8'h3C, 8'h05, 3'd0, 8'h41};
    vecs[1] = '{1'b1, OP_ROL, 8'h81, 8'h00, 3'd2, 8'h0C};
    vecs[2] = '{1'b0, OP_SUB, 8'h10, 8'h01, 3'd0, 8'h0F};
    vecs[3] = '{1'b1, OP_INV, 8'h0F, 8'h00, 3'd0, 8'hF0};
    vecs[4] = '{1'b0, OP_ROR, 8'h01, 8'h00, 3'd1, 8'h40};
    vecs[5] = '{1'b1, OP_DEC, 8'h05, 8'h00, 3'd3, 8'h01};
    vecs[6] = '{1'b0, OP_ADD, 8'hFF, 8'h02, 3'd0, 8'h01};
    vecs[7] = '{1'b0, OP_ADD, 8'h10, 8'h10, 3'd7, 8'h90};
`else
    vecs[0] = '{1'b0, OP_ADD, 8'h3C, 8'h05, 3'd0, 8'h41};
    vecs[1] = '{1'b1, OP_ROL, 8'h81, 8'h00, 3'd2, 8'h03};
    vecs[2] = '{1'b0, OP_SUB, 8'h10, 8'h01, 3'd0, 8'h0F};
    vecs[3] = '{1'b1, OP_INV, 8'h0F, 8'h00, 3'd0, 8'hF0};
    vecs[4] = '{1'b0, OP_ROR, 8'h01, 8'h00, 3'd1, 8'h80};
    vecs[5] = '{1'b1, OP_DEC, 8'h05, 8'h00, 3'd3, 8'h04};
    vecs[6] = '{1'b0, OP_ADD, 8'hFF, 8'h02, 3'd0, 8'h01};
    vecs[7] = '{1'b0, OP_ADD, 8'h10, 8'h10, 3'd7, 8'h20};
`endif

    rst = 1'b1;
    req_valid = 2'b00; rsp_ready = 2'b00;
    req_op = '0; req_a = '0; req_b = '0; req_rpt = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    $display("[TB] reset state");
    checkOutput("reset rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset rsp_data", 32'(rsp_data), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset alu_a", 32'(alu_a), 32'd0);
    checkOutput("reset alu_opcode", 32'(alu_opcode), 32'd0);
    checkOutput("reset req_ready idle", 32'(req_ready), 32'd0);

    $display("[TB] tie after reset, round robin");
    @(negedge clk);
    setPort(1'b0, OP_SUB, 8'h10, 8'h01, 3'd0);
    setPort(1'b1, OP_INV, 8'h0F, 8'h00, 3'd0);
    req_valid = 2'b11;
    #1 checkOutput("tie first grant", 32'(req_ready), 32'h1);
    @(posedge clk);
    #1 req_valid = 2'b10;
    checkOutput("ready low in EXEC", 32'(req_ready), 32'd0);
    waitRsp(lat);
    checkOutput("tie p0 rsp_valid", 32'(rsp_valid), 32'h1);
    checkOutput("tie p0 rsp_data", 32'(rsp_data), 32'h0F);
    rsp_ready = 2'b01;
    @(posedge clk);
    #1 rsp_ready = 2'b00;
    checkOutput("tie p1 granted next", 32'(req_ready), 32'h2);
    @(posedge clk);
    #1 req_valid = 2'b00;
    waitRsp(lat);
    checkOutput("tie p1 rsp_valid", 32'(rsp_valid), 32'h2);
    checkOutput("tie p1 rsp_data", 32'(rsp_data), 32'hF0);
    rsp_ready = 2'b10;
    @(posedge clk);
    #1 rsp_ready = 2'b00;
    req_valid = 2'b11;
    #1 checkOutput("second tie to p0", 32'(req_ready), 32'h1);
    req_valid = 2'b00;

    $display("[TB] backpressure with non-owner rsp_ready");
    @(negedge clk);
    setPort(1'b0, OP_ADD, 8'h01, 8'h01, 3'd0);
    setPort(1'b1, OP_INV, 8'h55, 8'h00, 3'd0);
    req_valid = 2'b11;
    #1 checkOutput("bp grant p0", 32'(req_ready), 32'h1);
    @(posedge clk);
    #1 req_valid = 2'b10;
    waitRsp(lat);
    rsp_ready = 2'b10;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("bp%0d rsp_valid", i), 32'(rsp_valid), 32'h1);
      checkOutput($sformatf("bp%0d rsp_data", i), 32'(rsp_data), 32'h02);
      checkOutput($sformatf("bp%0d busy", i), 32'(busy), 32'd1);
      checkOutput($sformatf("bp%0d req_ready", i), 32'(req_ready), 32'd0);
    end
    rsp_ready = 2'b01;
    @(posedge clk);
    #1 rsp_ready = 2'b00;
    checkOutput("bp p1 ready after release", 32'(req_ready), 32'h2);
    @(posedge clk);
    #1 req_valid = 2'b00;
    waitRsp(lat);
    checkOutput("bp p1 rsp_valid", 32'(rsp_valid), 32'h2);
    checkOutput("bp p1 rsp_data", 32'(rsp_data), 32'hAA);
    rsp_ready = 2'b10;
    @(posedge clk);
    #1 rsp_ready = 2'b00;

    $display("[TB] reset during EXEC");
    @(negedge clk);
    setPort(1'b1, OP_DEC, 8'h05, 8'h00, 3'd3);
    req_valid = 2'b10;
    @(posedge clk);
    #1 req_valid = 2'b00;
    checkOutput("midrst busy before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("midrst rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("midrst rsp_data", 32'(rsp_data), 32'd0);
    checkOutput("midrst busy", 32'(busy), 32'd0);
    checkOutput("midrst alu_a", 32'(alu_a), 32'd0);
    checkOutput("midrst alu_b", 32'(alu_b), 32'd0);
    checkOutput("midrst alu_opcode", 32'(alu_opcode), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("midrst quiet%0d", i), 32'(rsp_valid), 32'd0);
    end
    req_valid = 2'b11;
    #1 checkOutput("midrst tie to p0", 32'(req_ready), 32'h1);
    req_valid = 2'b00;

    $display("[TB] vector table");
    for (int i = 0; i < 8; i++) applyStimulus(vecs[i], i);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single 8-bit combinational ALU between two requesters: port 0 is the CPU core and port 1 is the scan/debug engine. The block arbitrates round-robin, registers the winner's operands, and drives the ALU. It can re-apply the same operation to its own result for a programmed number of extra passes, for example a multi-bit rotate or a repeated decrement. It then returns the registered result over a valid/ready handshake. It sits between the requesters and the ALU. The ALU's locking key is wired at top level and does not pass through this block.

## Interface
Parameters:
- DW, 8, data width; must match the ALU
- OPW, 4, opcode width
- RPTW, 3, repeat-count width

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  2  request valid, one bit per port; bit 0 is the CPU
- req_ready  out  2  request accepted this cycle; at most one bit high
- req_op  in  2×OPW  per-port ALU opcode
- req_a  in  2×DW  per-port operand A
- req_b  in  2×DW  per-port operand B
- req_rpt  in  2×RPTW  per-port count of extra passes (0 = single pass)
- rsp_valid  out  2  result valid to the owning port only
- rsp_ready  in  2  per-port result consumed
- rsp_data  out  DW  result; shared by both ports, qualified by rsp_valid
- alu_a  out  DW  ALU operand A
- alu_b  out  DW  ALU operand B
- alu_opcode  out  OPW  ALU opcode
- alu_y  in  DW  ALU result (combinational from alu_a/alu_b/alu_opcode)
- busy  out  1  high in EXEC or RESP

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - The grant goes to the requesting port. If both request, it goes to the port that was not granted last.
  - req_ready[grant] is asserted combinationally in IDLE while req_valid[grant] is high.
  - On accept: latch op, a, b, rpt and the owner index into op_r, a_r, b_r, cnt_r, own_r; go to EXEC.
- EXEC:
  - alu_a = a_r, alu_b = b_r, alu_opcode = op_r, all driven from registers.
  - Each cycle, alu_y is captured into res_r.
  - If cnt_r ≠ 0: a_r ← alu_y, cnt_r ← cnt_r − 1, stay in EXEC.
  - Else: go to RESP.
  - b_r and op_r stay constant for the whole sequence.
- RESP:
  - rsp_valid[own_r] = 1 and rsp_data = res_r.
  - Hold until rsp_ready[own_r] is high.
  - Then set last_grant ← own_r and go to IDLE.
  - rsp_ready on the non-owning port is ignored.
- No new request is accepted outside IDLE; req_ready = 0 in EXEC and RESP.
- All arithmetic and truncation come from the ALU. The block never modifies data and does not decode opcodes.

## Timing
- Accept in cycle N, the handshake cycle.
- EXEC runs for cycles N+1 … N+1+rpt.
- rsp_valid rises in cycle N+2+rpt.
- Back-to-back requests: after rsp handshake in cycle M, IDLE in M+1 can accept again. Minimum period is rpt+3 cycles.
- Reset values:
  - state = IDLE, last_grant = 1 (port 0 wins the first tie)
  - all operand, result and count registers = 0
  - rsp_valid = 0, rsp_data = 0, busy = 0, alu_* = 0
  - req_ready follows IDLE grant logic from the first cycle after reset.
- Reset asserted mid-EXEC or mid-RESP: the in-flight operation is dropped and no response is issued. The state is as above on the next cycle.
- A requester deasserting req_valid before acceptance is allowed. The grant is re-evaluated every IDLE cycle.
- rsp_data is stable while rsp_valid is high and not yet accepted.

## Configuration
- ALU_ARB_REPEAT_EN defined: repeat passes are active as described.
- Undefined: req_rpt is ignored and cnt_r is tied to 0. EXEC is always exactly one cycle and latency is fixed at 2 cycles. Ports are unchanged.

## Structure
- Package alu_arb_pkg holds:
  - the state enum (IDLE/EXEC/RESP)
  - DW, OPW and RPTW constants
  - the opcode constants used by benches: ADD 0000, SUB 0001, ROL 1000, ROR 1001, DEC 1010, INV 1011
- Sub-module rr_arb2 is a 2-way round-robin grant.
  - Inputs: req[1:0], last.
  - Output: one-hot gnt[1:0].
  - Purely combinational.

## Test plan
- Port 0: ADD a=0x3C b=0x05 rpt=0, rsp_ready=1 → req_ready[0] in cycle 0, rsp_valid[0] in cycle 2, rsp_data=0x41, rsp_valid[1]=0.
- Both ports valid in the same cycle after reset (p0 SUB 0x10,0x01; p1 INV 0x0F) → p0 granted first, result 0x0F. Then p1 is granted, result 0xF0. Then a further tie is granted to p0.
- Port 1: ROL a=0x81 rpt=2 (macro on) → 3 passes 0x81→0x03→0x06→0x0C; rsp_data=0x0C in cycle 4. With the macro off → 0x03 in cycle 2.
- Backpressure: hold rsp_ready[0]=0 for 5 cycles → rsp_valid and rsp_data stay stable, busy=1, req_ready=00 even with p1 valid. Release → p1 is accepted in the following cycle.
- rst pulsed during EXEC of DEC a=0x05 rpt=3 → no rsp_valid. All outputs are 0 next cycle and the next request is handled normally.
- rsp_ready[1] asserted while owner is p0 → no handshake; the FSM stays in RESP.
